enemy_wave_scheduler: RTL

Frame-rate controller that owns all enemy slots of the shooter. Once per frame it time-multiplexes a single hit-box test across every (enemy, bullet) pair. It keeps per-slot health, sequences each slot through alive, boom and dead states, and issues bullet-clear, kill-count and respawn pulses. It sits between the enemy/bullet position generators and the VGA sprite renderer.

---
 rtl/enemy_sched_pkg.sv | 31 +++
 rtl/hit_box_test.sv | 33 +++
 rtl/enemy_wave_scheduler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/enemy_sched_pkg.sv
// Shared types and constants for the enemy wave scheduler.
// Contents: slot-state and scan-state enums, coordinate width, default hit box.
// No logic; imported by the scheduler top and its hit-box sub-module.
package enemy_sched_pkg;

    localparam int COORD_W    = 10;
    localparam int HP_W       = 3;
    localparam int KILL_W     = 4;

    localparam int DEF_HIT_XL = 10;
    localparam int DEF_HIT_XR = 50;
    localparam int DEF_HIT_YT = 40;
    localparam int DEF_HIT_YB = 50;

    typedef enum logic [1:0] {
        SLOT_ALIVE = 2'd0,
        SLOT_BOOM  = 2'd1,
        SLOT_DEAD  = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hit_box_test.sv
// Single bullet-vs-enemy hit-box test; purely combinational, zero latency.
// Ports: i_ex/i_ey enemy origin, i_bx/i_by bullet position, o_hit result.
// No backpressure; evaluated every cycle for whatever pair is presented.
module hit_box_test
    import enemy_sched_pkg::*;
#(
    parameter int HIT_XL = DEF_HIT_XL,
    parameter int HIT_XR = DEF_HIT_XR,
    parameter int HIT_YT = DEF_HIT_YT,
    parameter int HIT_YB = DEF_HIT_YB
) (
    input  logic [COORD_W-1:0] i_ex,
    input  logic [COORD_W-1:0] i_ey,
    input  logic [COORD_W-1:0] i_bx,
    input  logic [COORD_W-1:0] i_by,
    output logic               o_hit
);
    // One extra bit so box edges past the screen border never wrap.
    localparam int AW = COORD_W + 1;

    logic [AW-1:0] w_ex, w_ey, w_bx, w_by;

    assign w_ex = {1'b0, i_ex};
    assign w_ey = {1'b0, i_ey};
    assign w_bx = {1'b0, i_bx};
    assign w_by = {1'b0, i_by};

    assign o_hit = ((w_bx + AW'(HIT_XL)) >= w_ex) &&
                   (w_bx < (w_ex + AW'(HIT_XR))) &&
                   ((w_by + AW'(HIT_YT)) > w_ey) &&
                   (w_by < (w_ey + AW'(HIT_YB)));

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Per-frame enemy slot controller: scans every (enemy, bullet) pair through one hit-box test, then commits.
// Latency: frame_tick at edge k -> commit_stb/bullet_clr/kill_cnt/spawn_req after edge k+N_ENEMY*N_BULLET+1.
// frame_tick while busy is dropped; producers hold positions/b_valid stable while busy=1.
module enemy_wave_scheduler
    import enemy_sched_pkg::*;
#(
    parameter int N_ENEMY        = 4,
    parameter int N_BULLET       = 4,
    parameter int MAX_HEALTH     = 3,
    parameter int BOOM_FRAMES    = 30,
    parameter int RESPAWN_FRAMES = 120,
    parameter int HIT_XL         = DEF_HIT_XL,
    parameter int HIT_XR         = DEF_HIT_XR,
    parameter int HIT_YT         = DEF_HIT_YT,
    parameter int HIT_YB         = DEF_HIT_YB
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic [COORD_W*N_ENEMY-1:0]   e_x_flat,
    input  logic [COORD_W*N_ENEMY-1:0]   e_y_flat,
    input  logic [COORD_W*N_BULLET-1:0]  b_x_flat,
    input  logic [COORD_W*N_BULLET-1:0]  b_y_flat,
    input  logic [N_BULLET-1:0]          b_valid,
    output logic [N_ENEMY-1:0]           enemy_en,
    output logic [N_ENEMY-1:0]           boom,
    output logic [HP_W*N_ENEMY-1:0]      health_flat,
    output logic [N_BULLET-1:0]          bullet_clr,
    output logic [N_ENEMY-1:0]           spawn_req,
    output logic [KILL_W-1:0]            kill_cnt,
    output logic                         commit_stb,
    output logic                         busy
);
    localparam int TMAX = max_int(max_int(BOOM_FRAMES, RESPAWN_FRAMES), 2);
    localparam int TW   = $clog2(TMAX);
    localparam int IW   = (N_ENEMY  > 1) ? $clog2(N_ENEMY)  : 1;
    localparam int JW   = (N_BULLET > 1) ? $clog2(N_BULLET) : 1;

    localparam logic [IW-1:0]   LAST_I    = IW'(N_ENEMY - 1);
    localparam logic [JW-1:0]   LAST_J    = JW'(N_BULLET - 1);
    localparam logic [HP_W-1:0] HP_FULL   = HP_W'(MAX_HEALTH);
    localparam logic [TW-1:0]   T_BOOM    = TW'(BOOM_FRAMES - 1);
    localparam logic [TW-1:0]   T_RESPAWN = TW'(RESPAWN_FRAMES - 1);

    scan_state_t        r_state, w_next;

    logic [IW-1:0]      r_i;
    logic [JW-1:0]      r_j;
    logic [N_BULLET-1:0] r_consumed;
    logic [KILL_W-1:0]  r_kill;

    slot_state_t        r_slot     [N_ENEMY];
    logic [TW-1:0]      r_timer    [N_ENEMY];
    logic [HP_W-1:0]    r_health   [N_ENEMY];   // committed, visible to renderer
    logic [HP_W-1:0]    r_hp_scan  [N_ENEMY];   // working copy updated pair by pair

    logic [COORD_W-1:0] w_ex, w_ey, w_bx, w_by;
    logic               w_box_hit, w_pair_hit, w_last;

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    assign w_last = (r_i == LAST_I) && (r_j == LAST_J);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (frame_tick) w_next = ST_SCAN;
            ST_SCAN:   if (w_last)     w_next = ST_COMMIT;
            ST_COMMIT:                 w_next = ST_IDLE;
            default:                   w_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    // ---------------- pair select and hit test ----------------
    assign w_ex = e_x_flat[int'(r_i) * COORD_W +: COORD_W];
    assign w_ey = e_y_flat[int'(r_i) * COORD_W +: COORD_W];
    assign w_bx = b_x_flat[int'(r_j) * COORD_W +: COORD_W];
    assign w_by = b_y_flat[int'(r_j) * COORD_W +: COORD_W];

    hit_box_test #(
        .HIT_XL (HIT_XL),
        .HIT_XR (HIT_XR),
        .HIT_YT (HIT_YT),
        .HIT_YB (HIT_YB)
    ) u_hit (
        .i_ex  (w_ex),
        .i_ey  (w_ey),
        .i_bx  (w_bx),
        .i_by  (w_by),
        .o_hit (w_box_hit)
    );

    // Working health/consumed state makes earlier pairs visible to later ones,
    // so the lowest enemy index claims a bullet first.
    assign w_pair_hit = w_box_hit && b_valid[r_j] && !r_consumed[r_j] &&
                        (r_slot[r_i] == SLOT_ALIVE) && (r_hp_scan[r_i] != '0);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i        <= '0;
            r_j        <= '0;
            r_consumed <= '0;
            r_kill     <= '0;
            bullet_clr <= '0;
            spawn_req  <= '0;
            kill_cnt   <= '0;
            commit_stb <= 1'b0;
            for (int k = 0; k < N_ENEMY; k++) begin
                r_slot[k]    <= SLOT_ALIVE;
                r_timer[k]   <= '0;
                r_health[k]  <= HP_FULL;
                r_hp_scan[k] <= HP_FULL;
            end
        end else begin
            bullet_clr <= '0;
            spawn_req  <= '0;
            kill_cnt   <= '0;
            commit_stb <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        r_i        <= '0;
                        r_j        <= '0;
                        r_consumed <= '0;
                        r_kill     <= '0;
                        for (int k = 0; k < N_ENEMY; k++) begin
                            r_hp_scan[k] <= r_health[k];
                        end
                    end
                end

                ST_SCAN: begin
                    if (w_pair_hit) begin
                        r_consumed[r_j] <= 1'b1;
                        r_hp_scan[r_i]  <= r_hp_scan[r_i] - 1'b1;
                        if ((r_hp_scan[r_i] == HP_W'(1)) && (r_kill != '1)) begin
                            r_kill <= r_kill + 1'b1;
                        end
                    end
                    if (r_j == LAST_J) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end

                ST_COMMIT: begin
                    bullet_clr <= r_consumed;
                    kill_cnt   <= r_kill;
                    commit_stb <= 1'b1;
                    for (int k = 0; k < N_ENEMY; k++) begin
                        case (r_slot[k])
                            SLOT_ALIVE: begin
                                r_health[k] <= r_hp_scan[k];
                                if (r_hp_scan[k] == '0) begin
                                    r_slot[k]  <= SLOT_BOOM;
                                    r_timer[k] <= T_BOOM;
                                end
                            end
                            SLOT_BOOM: begin
                                if (r_timer[k] == '0) begin
                                    r_slot[k]  <= SLOT_DEAD;
                                    r_timer[k] <= T_RESPAWN;
                                end else begin
                                    r_timer[k] <= r_timer[k] - 1'b1;
                                end
                            end
                            SLOT_DEAD: begin
                                if (r_timer[k] == '0) begin
                                    r_slot[k]    <= SLOT_ALIVE;
                                    r_health[k]  <= HP_FULL;
                                    spawn_req[k] <= 1'b1;
                                end else begin
                                    r_timer[k] <= r_timer[k] - 1'b1;
                                end
                            end
                            default: r_slot[k] <= SLOT_ALIVE;
                        endcase
                    end
                end

                default: ;
            endcase
        end
    end

    // ---------------- slot outputs ----------------
    always_comb begin
        enemy_en    = '0;
        boom        = '0;
        health_flat = '0;
        for (int k = 0; k < N_ENEMY; k++) begin
            enemy_en[k]                    = (r_slot[k] == SLOT_ALIVE);
            boom[k]                        = (r_slot[k] == SLOT_BOOM);
            health_flat[k * HP_W +: HP_W]  = r_health[k];
        end
    end

endmodule
